// File: rtl/pong_pkg.sv
// pong_pkg: VGA timing, playfield limits and ball FSM states shared by the pong game-logic blocks
package pong_pkg;

  localparam int H   = 640;
  localparam int HFP = 16;
  localparam int HS  = 96;
  localparam int HBP = 48;
  localparam int V   = 480;
  localparam int VFP = 10;
  localparam int VS  = 2;
  localparam int VBP = 33;

  localparam int H_START = HS + HBP;
  localparam int V_START = VS + VBP;

  localparam int BORDER       = 8;
  localparam int BALL_SIZE    = 16;
  localparam int BALL_SPEED   = 4;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_H     = 64;
  localparam int PADDLE_GAP   = 16;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 9;
  localparam int MAX_SPEED    = 8;

  localparam logic [10:0] TOP   = 11'(V_START + BORDER);
  localparam logic [10:0] BOT   = 11'(V_START + V - BORDER - BALL_SIZE);
  localparam logic [10:0] LFACE = 11'(H_START + PADDLE_GAP + PADDLE_W);
  localparam logic [10:0] RFACE = 11'(H_START + H - PADDLE_GAP - PADDLE_W - BALL_SIZE);
  localparam logic [10:0] LEDGE = 11'(H_START);
  localparam logic [10:0] REDGE = 11'(H_START + H - BALL_SIZE);
  localparam logic [9:0]  CX    = 10'(H_START + (H - BALL_SIZE) / 2);
  localparam logic [9:0]  CY    = 10'(V_START + (V - BALL_SIZE) / 2);

  typedef enum logic [1:0] {SERVE, MOVE, OVER} state_t;

endpackage

// File: rtl/pong_frame_tick.sv
// pong_frame_tick: one-cycle frame tick on the falling edge of the active-low V-sync
module pong_frame_tick (
  input  logic pixel_clock,
  input  logic reset,
  input  logic vga_vs,
  output logic tick
);

  logic vs_d;

  // delayed copy of V-sync for edge detection; cleared so reset never fakes an edge
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) vs_d <= 1'b0;
    else       vs_d <= vga_vs;
  end

  assign tick = vs_d & ~vga_vs;

endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: per-frame ball motion, paddle collisions, misses, serve delay and score; SPEEDUP_EN adds speed-up on hits
module pong_ball_engine
  import pong_pkg::*;
(
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       vga_vs,
  input  logic       start,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_visible,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       hit,
  output logic       miss
);

  state_t      state, state_n;
  logic        tick;
  logic        dir_x, dir_x_n, dir_y, dir_y_n;
  logic [5:0]  serve_cnt, serve_cnt_n;
  logic [9:0]  x_n, y_n;
  logic [3:0]  score_l_n, score_r_n;
  logic        hit_n, miss_n;
  logic [3:0]  speed;
  logic [10:0] sp, xe, ye, pl, pr, nx, ny;
  logic        ov_l, ov_r;

`ifdef SPEEDUP_EN
  logic [3:0] speed_n;
`else
  assign speed = 4'(BALL_SPEED);
`endif

  pong_frame_tick u_tick (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .vga_vs      (vga_vs),
    .tick        (tick)
  );

  assign sp   = {7'd0, speed};
  assign xe   = {1'b0, ball_x};
  assign ye   = {1'b0, ball_y};
  assign pl   = {1'b0, paddle_l_y};
  assign pr   = {1'b0, paddle_r_y};
  assign nx   = dir_x ? xe + sp : xe - sp;
  assign ny   = dir_y ? ye + sp : ye - sp;
  assign ov_l = (ye + 11'(BALL_SIZE) > pl) && (ye < pl + 11'(PADDLE_H));
  assign ov_r = (ye + 11'(BALL_SIZE) > pr) && (ye < pr + 11'(PADDLE_H));

  assign ball_visible = state != OVER;

  // game state register: restart, serve countdown, motion and scoring all land here
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state     <= SERVE;
      ball_x    <= CX;
      ball_y    <= CY;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      serve_cnt <= '0;
      score_l   <= '0;
      score_r   <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      state     <= state_n;
      ball_x    <= x_n;
      ball_y    <= y_n;
      dir_x     <= dir_x_n;
      dir_y     <= dir_y_n;
      serve_cnt <= serve_cnt_n;
      score_l   <= score_l_n;
      score_r   <= score_r_n;
      hit       <= hit_n;
      miss      <= miss_n;
    end
  end

`ifdef SPEEDUP_EN
  // speed register, only present when hits accelerate the ball
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) speed <= 4'(BALL_SPEED);
    else       speed <= speed_n;
  end
`endif

  // next-state: start beats a coincident tick; a miss overrides the vertical update
  always_comb begin
    state_n     = state;
    x_n         = ball_x;
    y_n         = ball_y;
    dir_x_n     = dir_x;
    dir_y_n     = dir_y;
    serve_cnt_n = serve_cnt;
    score_l_n   = score_l;
    score_r_n   = score_r;
    hit_n       = 1'b0;
    miss_n      = 1'b0;
`ifdef SPEEDUP_EN
    speed_n     = speed;
`endif
    if (start) begin
      state_n     = SERVE;
      x_n         = CX;
      y_n         = CY;
      dir_x_n     = 1'b1;
      serve_cnt_n = '0;
      score_l_n   = '0;
      score_r_n   = '0;
`ifdef SPEEDUP_EN
      speed_n     = 4'(BALL_SPEED);
`endif
    end else if (tick && state == SERVE) begin
      serve_cnt_n = serve_cnt == 6'(SERVE_FRAMES - 1) ? '0 : serve_cnt + 6'd1;
      state_n     = serve_cnt == 6'(SERVE_FRAMES - 1) ? MOVE : SERVE;
    end else if (tick && state == MOVE) begin
      y_n = ny[9:0];
      if (dir_y && ny >= BOT) begin
        y_n     = BOT[9:0];
        dir_y_n = 1'b0;
      end else if (!dir_y && ny <= TOP) begin
        y_n     = TOP[9:0];
        dir_y_n = 1'b1;
      end
      x_n = nx[9:0];
      if (!dir_x && nx <= LFACE && ov_l) begin
        x_n     = LFACE[9:0];
        dir_x_n = 1'b1;
        hit_n   = 1'b1;
      end else if (!dir_x && nx <= LEDGE) begin
        miss_n    = 1'b1;
        score_r_n = score_r + 4'd1;
        dir_x_n   = 1'b0;
      end else if (dir_x && nx >= RFACE && ov_r) begin
        x_n     = RFACE[9:0];
        dir_x_n = 1'b0;
        hit_n   = 1'b1;
      end else if (dir_x && nx >= REDGE) begin
        miss_n    = 1'b1;
        score_l_n = score_l + 4'd1;
        dir_x_n   = 1'b1;
      end
`ifdef SPEEDUP_EN
      if (hit_n) speed_n = speed == 4'(MAX_SPEED) ? speed : speed + 4'd1;
`endif
      if (miss_n) begin
        x_n         = CX;
        y_n         = CY;
        dir_y_n     = dir_y;
        serve_cnt_n = '0;
        state_n     = (score_l_n == 4'(WIN_SCORE) || score_r_n == 4'(WIN_SCORE)) ? OVER : SERVE;
`ifdef SPEEDUP_EN
        speed_n     = 4'(BALL_SPEED);
`endif
      end
    end
  end

endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed frame-by-frame checks of serve, bounces, paddle hits, misses, game over and restart
module tb_pong_ball_engine;

  logic       pixel_clock = 1'b0;
  logic       reset, vga_vs, start;
  logic [9:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
  logic       ball_visible, hit, miss;
  logic [3:0] score_l, score_r;
  int         total = 0;
  int         bad = 0;

  always #5 pixel_clock = ~pixel_clock;

  pong_ball_engine dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .vga_vs       (vga_vs),
    .start        (start),
    .paddle_l_y   (paddle_l_y),
    .paddle_r_y   (paddle_r_y),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .ball_visible (ball_visible),
    .score_l      (score_l),
    .score_r      (score_r),
    .hit          (hit),
    .miss         (miss)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge pixel_clock) vga_vs = 1'b0;
    @(negedge pixel_clock) vga_vs = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    reset = 1'b1;
    vga_vs = 1'b1;
    start = 1'b0;
    paddle_l_y = 10'd300;
    paddle_r_y = 10'd400;
    repeat (3) @(negedge pixel_clock);
    reset = 1'b0;
    @(negedge pixel_clock);
    check("rst_x", ball_x, 456);
    check("rst_y", ball_y, 267);
    check("rst_vis", ball_visible, 1);
    check("rst_sl", score_l, 0);
    check("rst_sr", score_r, 0);
    check("rst_hit", hit, 0);
    check("rst_miss", miss, 0);
    frame();
    check("serve1_x", ball_x, 456);
    frames(59);
    check("serve60_x", ball_x, 456);
    check("serve60_y", ball_y, 267);
    check("serve60_vis", ball_visible, 1);
    frame();
    check("move1_x", ball_x, 460);
    check("move1_y", ball_y, 271);
    frames(54);
    check("k55_y", ball_y, 487);
    frame();
    check("bot_clamp_y", ball_y, 491);
    check("k56_x", ball_x, 680);
    frame();
    check("bot_bounce_y", ball_y, 487);
    frames(14);
    check("k71_x", ball_x, 740);
    frame();
    check("rhit_x", ball_x, 744);
    check("rhit_pulse", hit, 1);
    @(negedge pixel_clock);
    check("rhit_clear", hit, 0);
    frames(149);
    check("l_approach_x", ball_x, 148);
    check("top_bounce_y", ball_y, 255);
    frame();
    check("lmiss_pulse", miss, 1);
    check("lmiss_sr", score_r, 1);
    check("lmiss_x", ball_x, 456);
    check("lmiss_y", ball_y, 267);
    @(negedge pixel_clock);
    check("lmiss_clear", miss, 0);
    paddle_l_y = 10'd400;
    paddle_r_y = 10'd900;
    frame();
    check("serve_hold_x", ball_x, 456);
    frames(59);
    frame();
    check("r2_move1_x", ball_x, 452);
    check("r2_move1_y", ball_y, 271);
    frames(71);
    check("lhit_x", ball_x, 168);
    check("lhit_pulse", hit, 1);
    frames(150);
    check("rmiss_pulse", miss, 1);
    check("rmiss_sl", score_l, 1);
    check("rmiss_x", ball_x, 456);
    for (int r = 2; r <= 8; r++) begin
      frames(138);
      check($sformatf("round%0d_sl", r), score_l, 16'(r));
    end
    frames(138);
    check("win_sl", score_l, 9);
    check("win_sr", score_r, 1);
    check("win_vis", ball_visible, 0);
    check("win_x", ball_x, 456);
    check("win_y", ball_y, 267);
    frames(5);
    check("over_x", ball_x, 456);
    check("over_sl", score_l, 9);
    check("over_vis", ball_visible, 0);
    @(negedge pixel_clock) start = 1'b1;
    @(negedge pixel_clock) start = 1'b0;
    check("restart_sl", score_l, 0);
    check("restart_sr", score_r, 0);
    check("restart_vis", ball_visible, 1);
    frames(60);
    check("restart_hold_x", ball_x, 456);
    frame();
    check("restart_move_x", ball_x, 460);
    frame();
    check("restart_move2_x", ball_x, 464);
    @(negedge pixel_clock) begin
      vga_vs = 1'b0;
      start = 1'b1;
    end
    @(negedge pixel_clock) begin
      vga_vs = 1'b1;
      start = 1'b0;
    end
    check("start_prio_x", ball_x, 456);
    frame();
    check("start_serve_x", ball_x, 456);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
